// File: rtl/std_gray_sync_decoder_if.sv
// rtl/std_gray_sync_decoder_if.sv - sample/result bundle between a Gray source and std_gray_sync_decoder
interface std_gray_sync_decoder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i_gray;
  logic             i_clear;
  logic             o_valid;
  logic [WIDTH-1:0] o_bin;
  logic             o_changed;
  logic [WIDTH-1:0] o_delta;
  logic             o_error;

  modport master (
    output i_gray,
    output i_clear,
    input  o_valid,
    input  o_bin,
    input  o_changed,
    input  o_delta,
    input  o_error
  );

  modport slave (
    input  i_gray,
    input  i_clear,
    output o_valid,
    output o_bin,
    output o_changed,
    output o_delta,
    output o_error
  );
endinterface

// File: rtl/std_gray_sync_decoder.sv
// rtl/std_gray_sync_decoder.sv - synchronise a foreign Gray counter, decode to binary, report step size
// Optional multi-bit-change checker enabled by STD_GRAY_SYNC_DECODER_CHECK_EN.
module std_gray_sync_decoder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  std_gray_sync_decoder_if.slave bus
);

  localparam int              CNT_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_CNT = CNT_W'(SYNC_STAGES + 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("std_gray_sync_decoder: WIDTH must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("std_gray_sync_decoder: SYNC_STAGES must be >= 2");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] bin_n;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             warm;

  // Pure flop-to-flop chain; nothing may sit between synchroniser stages.
  always_comb begin
    sync_d[0] = bus.i_gray;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Binary bit i is the XOR of all Gray bits from i upward.
  always_comb begin
    bin_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_n[i] = ^(sync_out >> i);
    end
  end

  assign warm = (cnt_q == WARM_CNT);

  always_comb begin
    cnt_d     = warm ? cnt_q : cnt_q + CNT_W'(1);
    bin_d     = bin_n;
    changed_d = warm && (bin_n != bin_q);
    delta_d   = changed_d ? (bin_n - bin_q) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      cnt_q     <= '0;
      bin_q     <= '0;
      changed_q <= 1'b0;
      delta_q   <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      changed_q <= changed_d;
      delta_q   <= delta_d;
    end
  end

  assign bus.o_valid   = warm;
  assign bus.o_bin     = bin_q;
  assign bus.o_changed = changed_q;
  assign bus.o_delta   = delta_q;

`ifdef STD_GRAY_SYNC_DECODER_CHECK_EN
  logic [WIDTH-1:0] prev_g_q, prev_g_d;
  logic [WIDTH-1:0] g_diff;
  logic             violation;
  logic             error_q, error_d;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  always_comb begin
    prev_g_d  = sync_out;
    g_diff    = sync_out ^ prev_g_q;
    violation = warm && ((g_diff & (g_diff - WIDTH'(1))) != '0);
    error_d   = error_q;
    if (violation) begin
      error_d = 1'b1;
    end else if (bus.i_clear) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      prev_g_q <= '0;
      error_q  <= 1'b0;
    end else begin
      prev_g_q <= prev_g_d;
      error_q  <= error_d;
    end
  end

  assign bus.o_error = error_q;
`else
  logic unused_clear;
  assign unused_clear = bus.i_clear;
  assign bus.o_error  = 1'b0;
`endif

endmodule

// File: tb/tb_std_gray_sync_decoder.sv
// tb/tb_std_gray_sync_decoder.sv - scoreboard bench for std_gray_sync_decoder
module tb_std_gray_sync_decoder;

  localparam int W = 16;
`ifdef STD_GRAY_SYNC_DECODER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  std_gray_sync_decoder_if #(.WIDTH(W)) bus ();

  std_gray_sync_decoder #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] bin;
    logic [W-1:0] delta;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] g, input logic [W-1:0] b, input logic [W-1:0] d);
    bus.i_gray = g;
    exp_q.push_back('{bin: b, delta: d});
  endtask

  // Monitor: every o_changed pulse must match the next queued update.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_changed === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_changed: o_bin 0x%0h o_delta 0x%0h, no update required", bus.o_bin, bus.o_delta);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_bin", 32'(bus.o_bin), 32'(mon_e.bin));
          check("sb_delta", 32'(bus.o_delta), 32'(mon_e.delta));
        end
      end else begin
        check("delta_idle", 32'(bus.o_delta), 32'h0);
      end
    end
  end

  initial begin
    logic [W-1:0] vv;
    bus.i_gray  = '0;
    bus.i_clear = 1'b0;
    rst_n       = 1'b0;
    tick(2);
    check("rst_valid",   32'(bus.o_valid),   32'h0);
    check("rst_bin",     32'(bus.o_bin),     32'h0);
    check("rst_changed", 32'(bus.o_changed), 32'h0);
    check("rst_delta",   32'(bus.o_delta),   32'h0);
    check("rst_error",   32'(bus.o_error),   32'h0);

    // Test 1: warm-up timing with a constant zero input
    rst_n = 1'b1;
    tick(1); check("t1_valid_e1", 32'(bus.o_valid), 32'h0);
    tick(1); check("t1_valid_e2", 32'(bus.o_valid), 32'h0);
    tick(1); check("t1_valid_e3", 32'(bus.o_valid), 32'h1);
    check("t1_bin", 32'(bus.o_bin), 32'h0);
    repeat (2) begin
      tick(1);
      check("t1_hold_bin",   32'(bus.o_bin),   32'h0);
      check("t1_hold_err",   32'(bus.o_error), 32'h0);
      check("t1_hold_valid", 32'(bus.o_valid), 32'h1);
    end

    // Test 2: count 1..7 in Gray, one step per 4 cycles
    for (int v = 1; v < 8; v++) begin
      vv = W'(v);
      drive(vv ^ (vv >> 1), vv, W'(1));
      tick(2);
      check("t2_bin_before", 32'(bus.o_bin), 32'(v - 1));
      tick(1);
      check("t2_bin_after", 32'(bus.o_bin), 32'(v));
      check("t2_err", 32'(bus.o_error), 32'h0);
      tick(1);
    end

    // Test 3: wrap 0xFFFF -> 0x0000, entering 0x8000 through reset
    rst_n       = 1'b0;
    bus.i_gray  = 16'h8000;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("t3_valid", 32'(bus.o_valid), 32'h1);
    check("t3_bin_top", 32'(bus.o_bin), 32'hFFFF);
    drive(16'h0000, 16'h0000, 16'h0001);
    tick(3);
    check("t3_bin_wrap", 32'(bus.o_bin), 32'h0);
    check("t3_err", 32'(bus.o_error), 32'h0);
    tick(1);

    // Test 4: legal step to 3, then a 2-bit jump to 5
    drive(16'h0002, 16'h0003, 16'h0003);
    tick(4);
    check("t4_bin3", 32'(bus.o_bin), 32'h3);
    check("t4_err_legal", 32'(bus.o_error), 32'h0);
    drive(16'h0007, 16'h0005, 16'h0002);
    tick(3);
    check("t4_bin5", 32'(bus.o_bin), 32'h5);
    check("t4_err_set", 32'(bus.o_error), 32'(CHK));
    tick(2);
    check("t4_err_sticky", 32'(bus.o_error), 32'(CHK));
    bus.i_clear = 1'b1;
    tick(1);
    bus.i_clear = 1'b0;
    check("t4_err_clear", 32'(bus.o_error), 32'h0);
    tick(1);
    check("t4_err_stays_clear", 32'(bus.o_error), 32'h0);

    // Test 5: clear coincides with a fresh violation, set must win
    drive(16'h0004, 16'h0007, 16'h0002);
    tick(3);
    check("t5_bin7", 32'(bus.o_bin), 32'h7);
    check("t5_err_set", 32'(bus.o_error), 32'(CHK));
    drive(16'h0007, 16'h0005, 16'hFFFE);
    tick(2);
    bus.i_clear = 1'b1;
    tick(1);
    bus.i_clear = 1'b0;
    check("t5_bin5", 32'(bus.o_bin), 32'h5);
    check("t5_err_set_wins", 32'(bus.o_error), 32'(CHK));
    tick(1);
    check("t5_err_after", 32'(bus.o_error), 32'(CHK));

    // Test 6: asynchronous reset mid-operation, restart on a nonzero input
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(bus.o_valid),   32'h0);
    check("t6_bin",   32'(bus.o_bin),     32'h0);
    check("t6_chg",   32'(bus.o_changed), 32'h0);
    check("t6_delta", 32'(bus.o_delta),   32'h0);
    check("t6_err",   32'(bus.o_error),   32'h0);
    tick(2);
    check("t6_held_valid", 32'(bus.o_valid), 32'h0);
    rst_n = 1'b1;
    tick(1); check("t6_valid_e1", 32'(bus.o_valid), 32'h0);
    check("t6_bin_e1", 32'(bus.o_bin), 32'h0);
    tick(1); check("t6_valid_e2", 32'(bus.o_valid), 32'h0);
    tick(1); check("t6_valid_e3", 32'(bus.o_valid), 32'h1);
    check("t6_bin_e3", 32'(bus.o_bin), 32'h5);
    tick(4);
    check("t6_bin_hold", 32'(bus.o_bin), 32'h5);
    check("t6_err_hold", 32'(bus.o_error), 32'h0);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/std_gray_sync_decoder.md
Name: std_gray_sync_decoder

Overview:
- Receiving end of a Gray-coded counter crossing into this clock domain, for example an async FIFO pointer or a free-running timestamp.
- Flop-synchronises the foreign Gray vector, decodes it to binary (prefix XOR), registers the result, and reports the per-sample step size.
- Optionally flags Gray protocol violations, i.e. a sample change of more than one bit.
- Sits on the destination side, opposite the binary-to-Gray encoder on the source side.

Parameters:
- WIDTH, 16, bit width of the Gray input and all binary outputs; must be ≥ 2.
- SYNC_STAGES, 2, synchroniser flop count; must be ≥ 2.

Ports:
- i_clk  input  1  destination-domain clock, rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_gray  input  WIDTH  Gray-coded value from foreign domain; asynchronous to i_clk.
- i_clear  input  1  synchronous clear of sticky o_error.
- o_valid  output  1  high once the pipeline holds a real sample since reset.
- o_bin  output  WIDTH  decoded binary value.
- o_changed  output  1  one-cycle pulse: o_bin updated to a different value this cycle.
- o_delta  output  WIDTH  (new o_bin − previous o_bin) mod 2^WIDTH; valid when o_changed = 1, else 0.
- o_error  output  1  sticky: multi-bit Gray change detected (feature-dependent).

Behaviour:
- Reset (i_rst = 0, async assert, sync deassert by the integrator):
  - all sync flops, prev-Gray register and warm-up counter → 0;
  - o_valid = 0, o_bin = 0, o_changed = 0, o_delta = 0, o_error = 0.
- Sync chain: s[0] <= i_gray, s[k] <= s[k-1]; sync_out = s[SYNC_STAGES-1]. No logic between sync flops.
- Decode is combinational on sync_out: bin_n[WIDTH-1] = g[WIDTH-1]; bin_n[i] = g[i] ^ bin_n[i+1].
- Output register: o_bin <= bin_n every cycle.
- Latency: a stable i_gray appears on o_bin after SYNC_STAGES+1 rising edges.
- Warm-up counter:
  - counts edges after reset, saturating at SYNC_STAGES+1;
  - o_valid = 1 once saturated and stays high until next reset.
- Change detection, evaluated on the same edge that loads o_bin:
  - if warm (counter ≥ SYNC_STAGES+1 before the edge) and bin_n ≠ o_bin: o_changed <= 1, o_delta <= bin_n − o_bin (WIDTH-bit wrap);
  - otherwise o_changed <= 0, o_delta <= 0.
  - The first sample after reset never raises o_changed. This suppresses the spurious step from reset value 0.
- Wrap-around: Gray 0x8000 → 0x0000 (WIDTH = 16) decodes as 0xFFFF → 0x0000, giving o_delta = 1, o_changed = 1.
- Input unchanged: o_bin holds, o_changed = 0, o_delta = 0.
- Reset mid-operation: all state clears immediately; warm-up restarts; no o_changed pulse on the first post-reset sample.
- o_error is described under Optional Feature. With both set and clear in the same cycle, set wins and o_error stays 1.

Optional Feature:
- Macro: STD_GRAY_SYNC_DECODER_CHECK_EN.
- Defined:
  - register prev_g <= sync_out each cycle;
  - when warm and popcount(sync_out ^ prev_g) > 1, o_error <= 1, sticky;
  - i_clear = 1 without a coincident violation → o_error <= 0;
  - the violating sample is still decoded and reported normally.
- Undefined:
  - prev_g and popcount logic are absent;
  - o_error is tied to 0 and i_clear is ignored;
  - the port list is unchanged.

Test Plan:
1. Reset, then hold i_gray = 0 for 5 cycles:
   - o_valid rises exactly 3 edges after reset release (SYNC_STAGES = 2);
   - o_bin = 0, o_changed = 0, o_error = 0 throughout.
2. Step i_gray through gray(0..7) = 0,1,3,2,6,7,5,4, one value per 4 cycles:
   - o_bin = 0..7, each 3 edges after its input change;
   - each update gives one o_changed pulse with o_delta = 1.
3. Wrap: i_gray 0x8000 (bin 0xFFFF), then 0x0000:
   - o_bin goes 0xFFFF → 0x0000 with o_changed = 1, o_delta = 0x0001, o_error = 0.
4. Jump: i_gray 0x0002 (bin 3), then 0x0007 (bin 5), a 2-bit change:
   - o_delta = 2, o_changed = 1;
   - with macro: o_error = 1, stays set;
   - i_clear for 1 cycle → o_error = 0;
   - without macro: o_error = 0 throughout.
5. Simultaneous i_clear and a new 2-bit violation (macro defined):
   - o_error remains 1.
6. Assert i_rst while o_bin = 5, o_error = 1:
   - all outputs are 0 immediately;
   - after release with i_gray = 0x0007 (bin 5), o_valid rises after 3 edges, o_bin = 5, and o_changed never pulses.
